// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU memory-bus arbiter.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_DM = 1'b1;

    // Instruction word sits in the upper half of the 64-bit RAM word.
    localparam int unsigned IF_SLICE_HI = 63;
    localparam int unsigned IF_SLICE_LO = 32;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: on a tie the port that did not own the bus last wins.
module rr_arb2
    import cpu_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last_owner == OWNER_DM) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and load/store, holding the
// strobes for WAIT_CYCLES cycles and returning a one-cycle ack with read data.
module mem_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int unsigned ADDR_W      = 64,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wdata_oe,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ram_cs,
    output logic              ram_we,
    output logic              ram_oe,
    output logic              busy
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    if (WAIT_CYCLES == 0) begin : g_wait_check
        $error("mem_arbiter: WAIT_CYCLES must be >= 1");
    end

    state_t             r_state,      w_state_nxt;
    logic [CNT_W-1:0]   r_cnt,        w_cnt_nxt;
    logic               r_owner,      w_owner_nxt;
    logic               r_we,         w_we_nxt;
    logic               r_last_owner, w_last_owner_nxt;
    logic               r_if_ack,     w_if_ack_nxt;
    logic               r_dm_ack,     w_dm_ack_nxt;
    logic [31:0]        r_if_rdata,   w_if_rdata_nxt;
    logic [DATA_W-1:0]  r_dm_rdata,   w_dm_rdata_nxt;
    logic [ADDR_W-1:0]  r_ram_addr,   w_ram_addr_nxt;
    logic [DATA_W-1:0]  r_ram_wdata,  w_ram_wdata_nxt;
    logic               r_ram_wdata_oe, w_ram_wdata_oe_nxt;
    logic               r_ram_cs,     w_ram_cs_nxt;
    logic               r_ram_we,     w_ram_we_nxt;
    logic               r_ram_oe,     w_ram_oe_nxt;
    logic               r_busy,       w_busy_nxt;
    logic [1:0]         w_gnt;

    rr_arb2 u_rr_arb2 (
        .req        ({dm_req, if_req}),
        .last_owner (r_last_owner),
        .gnt        (w_gnt)
    );

    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = r_cnt;
        w_owner_nxt        = r_owner;
        w_we_nxt           = r_we;
        w_last_owner_nxt   = r_last_owner;
        w_if_ack_nxt       = 1'b0;
        w_dm_ack_nxt       = 1'b0;
        w_if_rdata_nxt     = r_if_rdata;
        w_dm_rdata_nxt     = r_dm_rdata;
        w_ram_addr_nxt     = r_ram_addr;
        w_ram_wdata_nxt    = r_ram_wdata;
        w_ram_wdata_oe_nxt = r_ram_wdata_oe;
        w_ram_cs_nxt       = r_ram_cs;
        w_ram_we_nxt       = r_ram_we;
        w_ram_oe_nxt       = r_ram_oe;
        w_busy_nxt         = r_busy;

        case (r_state)
            IDLE: begin
                if (|w_gnt) begin
                    w_owner_nxt        = w_gnt[1] ? OWNER_DM : OWNER_IF;
                    w_we_nxt           = w_gnt[1] & dm_we;
                    w_ram_addr_nxt     = w_gnt[1] ? dm_addr : if_addr;
                    w_ram_wdata_nxt    = w_gnt[1] ? dm_wdata : '0;
                    w_ram_cs_nxt       = 1'b1;
                    w_ram_we_nxt       = w_gnt[1] & dm_we;
                    w_ram_oe_nxt       = ~(w_gnt[1] & dm_we);
                    w_ram_wdata_oe_nxt = w_gnt[1] & dm_we;
                    w_busy_nxt         = 1'b1;
                    w_cnt_nxt          = CNT_W'(WAIT_CYCLES - 1);
                    w_state_nxt        = ACCESS;
                end
            end
            ACCESS: begin
                if (r_cnt == '0) begin
                    // Read data is taken on the same edge the strobes drop.
                    if (!r_we) begin
                        if (r_owner == OWNER_IF) begin
                            w_if_rdata_nxt = ram_rdata[IF_SLICE_HI:IF_SLICE_LO];
                        end else begin
                            w_dm_rdata_nxt = ram_rdata;
                        end
                    end
                    w_ram_cs_nxt       = 1'b0;
                    w_ram_we_nxt       = 1'b0;
                    w_ram_oe_nxt       = 1'b0;
                    w_ram_wdata_oe_nxt = 1'b0;
                    w_if_ack_nxt       = (r_owner == OWNER_IF);
                    w_dm_ack_nxt       = (r_owner == OWNER_DM);
                    w_state_nxt        = RESP;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            RESP: begin
                w_last_owner_nxt = r_owner;
                w_busy_nxt       = 1'b0;
                w_state_nxt      = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_owner        <= OWNER_IF;
            r_we           <= 1'b0;
            r_last_owner   <= OWNER_DM;
            r_if_ack       <= 1'b0;
            r_dm_ack       <= 1'b0;
            r_if_rdata     <= '0;
            r_dm_rdata     <= '0;
            r_ram_addr     <= '0;
            r_ram_wdata    <= '0;
            r_ram_wdata_oe <= 1'b0;
            r_ram_cs       <= 1'b0;
            r_ram_we       <= 1'b0;
            r_ram_oe       <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_owner        <= w_owner_nxt;
            r_we           <= w_we_nxt;
            r_last_owner   <= w_last_owner_nxt;
            r_if_ack       <= w_if_ack_nxt;
            r_dm_ack       <= w_dm_ack_nxt;
            r_if_rdata     <= w_if_rdata_nxt;
            r_dm_rdata     <= w_dm_rdata_nxt;
            r_ram_addr     <= w_ram_addr_nxt;
            r_ram_wdata    <= w_ram_wdata_nxt;
            r_ram_wdata_oe <= w_ram_wdata_oe_nxt;
            r_ram_cs       <= w_ram_cs_nxt;
            r_ram_we       <= w_ram_we_nxt;
            r_ram_oe       <= w_ram_oe_nxt;
            r_busy         <= w_busy_nxt;
        end
    end

    assign if_ack       = r_if_ack;
    assign dm_ack       = r_dm_ack;
    assign if_rdata     = r_if_rdata;
    assign dm_rdata     = r_dm_rdata;
    assign ram_addr     = r_ram_addr;
    assign ram_wdata    = r_ram_wdata;
    assign ram_wdata_oe = r_ram_wdata_oe;
    assign ram_cs       = r_ram_cs;
    assign ram_we       = r_ram_we;
    assign ram_oe       = r_ram_oe;
    assign busy         = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: RAM model plus an ack-driven scoreboard.
module tb_mem_arbiter;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned WC = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ack;
    logic [31:0]   if_rdata;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic          dm_ack;
    logic [DW-1:0] dm_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_wdata_oe;
    logic [DW-1:0] ram_rdata = '0;
    logic          ram_cs, ram_we, ram_oe, busy;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wdata_oe(ram_wdata_oe),
        .ram_rdata(ram_rdata), .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
        .busy(busy)
    );

    typedef struct {
        bit          dm;
        bit          we;
        logic [63:0] addr;
        logic [63:0] data;
    } txn_t;

    txn_t        sb[$];
    txn_t        mon_e;
    logic [63:0] mem [logic [63:0]];
    int          checks = 0;
    int          failures = 0;
    logic [63:0] exp_dm_rdata = '0;
    logic [31:0] exp_if_rdata = '0;
    bit          prev_ack = 1'b0;

    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        return {~a[31:0], a[31:0] + 32'h3};
    endfunction

    // RAM model: data presented by the negedge after the strobes, writes on posedge.
    always @(negedge clk) ram_rdata = (ram_cs && ram_oe) ? mem_rd(ram_addr) : '0;
    always @(posedge clk) if (!reset && ram_cs && ram_we) mem[ram_addr] = ram_wdata;

    // Scoreboard: every ack pops the oldest expected transaction.
    always @(negedge clk) begin
        if (reset) begin
            prev_ack = 1'b0;
        end else begin
            if (if_ack || dm_ack) begin
                checks++;
                if (prev_ack) begin
                    failures++;
                    $display("FAIL ack_width: ack high two cycles running, required one cycle");
                end
                checks++;
                if (sb.size() == 0 || (if_ack && dm_ack)) begin
                    failures++;
                    $display("FAIL sb_ack: unexpected ack if_ack=%0b dm_ack=%0b queued=%0d",
                             if_ack, dm_ack, sb.size());
                end else begin
                    mon_e = sb.pop_front();
                    checks++;
                    if (dm_ack !== mon_e.dm) begin
                        failures++;
                        $display("FAIL sb_owner: dm_ack=%0b required %0b (addr %h)",
                                 dm_ack, mon_e.dm, mon_e.addr);
                    end
                    if (!mon_e.dm) exp_if_rdata = mon_e.data[63:32];
                    else if (!mon_e.we) exp_dm_rdata = mon_e.data;
                    checks++;
                    if (if_rdata !== exp_if_rdata || dm_rdata !== exp_dm_rdata) begin
                        failures++;
                        $display("FAIL sb_rdata: if_rdata=%h dm_rdata=%h required %h / %h",
                                 if_rdata, dm_rdata, exp_if_rdata, exp_dm_rdata);
                    end
                end
            end
            prev_ack = if_ack || dm_ack;
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        if_req = 1'b0;
        dm_req = 1'b0;
        sb.delete();
        exp_dm_rdata = '0;
        exp_if_rdata = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_ack(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (if_ack || dm_ack) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({if_ack, dm_ack, busy, ram_cs, ram_we, ram_oe, ram_wdata_oe} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl: ack/busy/strobes=%b required 0000000",
                     {if_ack, dm_ack, busy, ram_cs, ram_we, ram_oe, ram_wdata_oe});
        end
        checks++;
        if (if_rdata !== '0 || dm_rdata !== '0 || ram_addr !== '0 || ram_wdata !== '0) begin
            failures++;
            $display("FAIL reset_data: if_rdata=%h dm_rdata=%h ram_addr=%h ram_wdata=%h required 0",
                     if_rdata, dm_rdata, ram_addr, ram_wdata);
        end
        do_reset();
    endtask

    task automatic test_if_read();
        if_addr = 64'h10;
        if_req = 1'b1;
        sb.push_back('{dm: 1'b0, we: 1'b0, addr: 64'h10, data: mem_rd(64'h10)});
        @(posedge clk);
        for (int c = 0; c < int'(WC); c++) begin
            @(negedge clk);
            checks++;
            if ({ram_cs, ram_oe, ram_we, ram_wdata_oe, busy, if_ack} !== 6'b110010 || ram_addr !== 64'h10) begin
                failures++;
                $display("FAIL if_access c%0d: cs/oe/we/wdoe/busy/ack=%b addr=%h required 110010 addr=10",
                         c, {ram_cs, ram_oe, ram_we, ram_wdata_oe, busy, if_ack}, ram_addr);
            end
        end
        @(negedge clk);
        checks++;
        if (if_ack !== 1'b1 || ram_cs !== 1'b0 || if_rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL if_ack_timing: if_ack=%b ram_cs=%b if_rdata=%h required 1 0 deadbeef",
                     if_ack, ram_cs, if_rdata);
        end
        @(posedge clk); #1 if_req = 1'b0;
        @(negedge clk);
        checks++;
        if (if_ack !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL if_done: if_ack=%b busy=%b required 0 0", if_ack, busy);
        end
    endtask

    task automatic test_dm_store();
        @(posedge clk); #1;
        dm_we = 1'b1;
        dm_addr = 64'h100;
        dm_wdata = 64'h11223344_55667788;
        dm_req = 1'b1;
        sb.push_back('{dm: 1'b1, we: 1'b1, addr: 64'h100, data: 64'h11223344_55667788});
        @(posedge clk);
        for (int c = 0; c < int'(WC); c++) begin
            @(negedge clk);
            checks++;
            if ({ram_cs, ram_we, ram_wdata_oe, ram_oe} !== 4'b1110 || ram_wdata !== 64'h11223344_55667788
                || ram_addr !== 64'h100) begin
                failures++;
                $display("FAIL dm_store c%0d: cs/we/wdoe/oe=%b wdata=%h addr=%h required 1110 1122334455667788 100",
                         c, {ram_cs, ram_we, ram_wdata_oe, ram_oe}, ram_wdata, ram_addr);
            end
        end
        @(negedge clk);
        checks++;
        if (dm_ack !== 1'b1 || ram_wdata_oe !== 1'b0 || dm_rdata !== 64'h0) begin
            failures++;
            $display("FAIL dm_store_ack: dm_ack=%b wdata_oe=%b dm_rdata=%h required 1 0 0",
                     dm_ack, ram_wdata_oe, dm_rdata);
        end
        @(posedge clk); #1 dm_req = 1'b0; dm_we = 1'b0;
    endtask

    task automatic test_simultaneous();
        bit drop_if, drop_dm, prev_cs, overlap;
        int n_acks, cs_rises;
        do_reset();
        if_addr = 64'h20;
        dm_addr = 64'h200;
        dm_we = 1'b0;
        if_req = 1'b1;
        dm_req = 1'b1;
        sb.push_back('{dm: 1'b0, we: 1'b0, addr: 64'h20, data: mem_rd(64'h20)});
        sb.push_back('{dm: 1'b1, we: 1'b0, addr: 64'h200, data: mem_rd(64'h200)});
        n_acks = 0; cs_rises = 0; prev_cs = 1'b0; overlap = 1'b0;
        for (int c = 0; c < 30 && n_acks < 2; c++) begin
            @(negedge clk);
            if (ram_cs && !prev_cs) cs_rises++;
            prev_cs = ram_cs;
            if (ram_cs && (if_ack || dm_ack)) overlap = 1'b1;
            drop_if = if_ack;
            drop_dm = dm_ack;
            if (if_ack || dm_ack) n_acks++;
            @(posedge clk); #1;
            if (drop_if) if_req = 1'b0;
            if (drop_dm) dm_req = 1'b0;
        end
        checks++;
        if (n_acks != 2 || cs_rises != 2 || overlap) begin
            failures++;
            $display("FAIL simultaneous: acks=%0d cs_rises=%0d overlap=%0b required 2 2 0",
                     n_acks, cs_rises, overlap);
        end
        checks++;
        if (dm_rdata !== mem_rd(64'h200)) begin
            failures++;
            $display("FAIL simul_dm_rdata: dm_rdata=%h required %h", dm_rdata, mem_rd(64'h200));
        end
    endtask

    task automatic test_fairness();
        int n_acks, low_run, gaps;
        bit seen_busy;
        do_reset();
        if_addr = 64'h30;
        dm_addr = 64'h400;
        dm_we = 1'b0;
        if_req = 1'b1;
        dm_req = 1'b1;
        for (int t = 0; t < 4; t++) begin
            if (t % 2 == 0) sb.push_back('{dm: 1'b0, we: 1'b0, addr: 64'h30, data: mem_rd(64'h30)});
            else            sb.push_back('{dm: 1'b1, we: 1'b0, addr: 64'h400, data: mem_rd(64'h400)});
        end
        n_acks = 0; low_run = 0; gaps = 0; seen_busy = 1'b0;
        for (int c = 0; c < 60 && n_acks < 4; c++) begin
            @(negedge clk);
            if (!busy) begin
                low_run++;
            end else begin
                if (seen_busy && low_run > 0) begin
                    gaps++;
                    checks++;
                    if (low_run != 1) begin
                        failures++;
                        $display("FAIL fair_gap%0d: busy low %0d cycles required 1", gaps, low_run);
                    end
                end
                low_run = 0;
                seen_busy = 1'b1;
            end
            if (if_ack || dm_ack) n_acks++;
        end
        @(posedge clk); #1 if_req = 1'b0; dm_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (n_acks != 4 || gaps != 3 || busy !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("FAIL fairness: acks=%0d gaps=%0d busy=%b pending=%0d required 4 3 0 0",
                     n_acks, gaps, busy, sb.size());
        end
    endtask

    task automatic test_reset_mid_access();
        bit seen, stray;
        @(posedge clk); #1;
        dm_we = 1'b1;
        dm_addr = 64'h500;
        dm_wdata = 64'hCAFEF00D_12345678;
        dm_req = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ram_cs !== 1'b1 || ram_wdata_oe !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_pre: ram_cs=%b wdata_oe=%b required 1 1", ram_cs, ram_wdata_oe);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({ram_cs, ram_we, ram_wdata_oe, busy} !== 4'b0 || dm_rdata !== '0) begin
            failures++;
            $display("FAIL rst_mid_async: cs/we/wdoe/busy=%b dm_rdata=%h required 0000 0",
                     {ram_cs, ram_we, ram_wdata_oe, busy}, dm_rdata);
        end
        dm_req = 1'b0;
        dm_we = 1'b0;
        sb.delete();
        exp_dm_rdata = '0;
        exp_if_rdata = '0;
        @(posedge clk); #1 reset = 1'b0;
        stray = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (dm_ack || if_ack || busy) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            failures++;
            $display("FAIL rst_mid_noack: ack or busy seen after reset, required none");
        end
        @(posedge clk); #1;
        if_addr = 64'h40;
        if_req = 1'b1;
        sb.push_back('{dm: 1'b0, we: 1'b0, addr: 64'h40, data: mem_rd(64'h40)});
        wait_ack(20, seen);
        checks++;
        if (!seen || if_ack !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_recover: if_ack seen=%0b if_ack=%b required 1 1", seen, if_ack);
        end
        @(posedge clk); #1 if_req = 1'b0;
    endtask

    task automatic test_operand_stability();
        bit seen;
        @(posedge clk); #1;
        dm_we = 1'b0;
        dm_addr = 64'h300;
        dm_req = 1'b1;
        sb.push_back('{dm: 1'b1, we: 1'b0, addr: 64'h300, data: mem_rd(64'h300)});
        @(posedge clk);
        #1 dm_addr = 64'h308;
        for (int c = 0; c < int'(WC); c++) begin
            @(negedge clk);
            checks++;
            if (ram_cs !== 1'b1 || ram_addr !== 64'h300) begin
                failures++;
                $display("FAIL stable_addr c%0d: ram_cs=%b ram_addr=%h required 1 300", c, ram_cs, ram_addr);
            end
        end
        wait_ack(10, seen);
        checks++;
        if (!seen || dm_rdata !== mem_rd(64'h300)) begin
            failures++;
            $display("FAIL stable_data: seen=%0b dm_rdata=%h required 1 %h", seen, dm_rdata, mem_rd(64'h300));
        end
        @(posedge clk); #1 dm_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        mem[64'h10] = 64'hDEADBEEF_00000013;
        test_reset();
        test_if_read();
        test_dm_store();
        test_simultaneous();
        test_fairness();
        test_reset_mid_access();
        test_operand_stability();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single RAM port between the CPU's two requesters: instruction fetch (IF) and load/store data (DM).
- Arbitrates round-robin and latches the winner's address, write data and direction.
- Drives the RAM control signals ram_cs, ram_we and ram_oe for a fixed number of wait cycles, then returns a one-cycle ack with read data.
- Sits between the fetch/LSU logic in cpu and the shared 64-bit bus. The ctrl block no longer drives RAM strobes directly.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, bus data width.
- WAIT_CYCLES, 2, cycles the strobes are held per access. Must be >= 1; an elaboration-time check fails on 0.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch address.
- if_ack  out  1  one-cycle fetch completion.
- if_rdata  out  32  instruction, equal to bits [63:32] of the RAM word.
- dm_req  in  1  data request.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_ack  out  1  one-cycle data completion.
- dm_rdata  out  DATA_W  load data.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  data toward the bus.
- ram_wdata_oe  out  1  bus tri-state enable. The top level drives the bus only when this is 1.
- ram_rdata  in  DATA_W  data from the bus.
- ram_cs  out  1  RAM chip select.
- ram_we  out  1  RAM write enable.
- ram_oe  out  1  RAM output enable.
- busy  out  1  high in ACCESS and RESP.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- All outputs are registered.
- Reset values: every output is 0, the FSM is in IDLE, the wait counter is 0, and last_owner = DM, so IF wins the first tie.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Samples if_req and dm_req. With no request, stay in IDLE.
  - With one request, grant it.
  - With both, grant the port that is not last_owner.
  - On the grant edge, latch owner, address, we (IF is always a read), and wdata.
  - Load the counter with WAIT_CYCLES-1 and go to ACCESS.
- ACCESS outputs:
  - ram_cs = 1.
  - ram_we = latched we; ram_oe = !latched we; ram_wdata_oe = latched we.
  - ram_addr and ram_wdata = latched values.
- ACCESS timing:
  - The counter decrements each cycle.
  - On the edge where the counter is 0: for a read, capture ram_rdata; go to RESP; drop all strobes and ram_wdata_oe on the same edge.
  - A read captures ram_rdata as sampled at the last ACCESS edge; the RAM must present data within WAIT_CYCLES cycles of ram_cs rising.
- RESP:
  - Assert the owner's ack for exactly one cycle.
  - Update last_owner to the owner. Return to IDLE.
- Read data registers:
  - if_rdata and dm_rdata update only on a read by that port.
  - They hold their value otherwise; a write leaves dm_rdata unchanged.
- Latency: the access takes WAIT_CYCLES cycles in ACCESS. The ack appears WAIT_CYCLES+1 cycles after the grant edge. Minimum request-to-ack spacing is WAIT_CYCLES+2 cycles.
- Requester handshake:
  - Hold req and all operands stable until ack is seen.
  - Drop req on the edge that samples ack=1, unless a back-to-back request is wanted.
  - A req still high in the next IDLE cycle is a new request.
- Request changes during ACCESS/RESP are ignored, because operands are latched. A late req from the other port waits in IDLE.
- Held requests from both ports alternate strictly (IF, DM, IF, ...), so neither port starves.
- Reset during ACCESS or RESP:
  - The FSM returns to IDLE immediately and asynchronously.
  - Strobes and ram_wdata_oe drop, no ack is issued, and the in-flight transaction is lost.
  - Read data registers clear to 0.
- No alignment or address-range checking; addresses pass through unchanged.

Decomposition:
- Package cpu_bus_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - owner constants OWNER_IF=1'b0 and OWNER_DM=1'b1;
  - the IF_SLICE_HI=63 and IF_SLICE_LO=32 constants.
- Sub-module rr_arb2: 2-input round-robin arbiter.
  - Inputs: req[1:0], last_owner.
  - Outputs: gnt[1:0], combinational one-hot.
- The FSM, counter and latches stay in mem_arbiter.

Test Plan:
1. IF read, WAIT_CYCLES=2. After reset, if_req with if_addr=0x10; RAM returns 0xDEADBEEF_00000013. Required: ram_cs=ram_oe=1 and ram_addr=0x10 for 2 cycles; ram_we=0; if_ack high for 1 cycle, 3 cycles after the grant edge; if_rdata=0xDEADBEEF.
2. DM store. dm_we=1, dm_addr=0x100, dm_wdata=0x11223344_55667788. Required: ram_we=ram_cs=ram_wdata_oe=1, ram_oe=0, ram_wdata equal to dm_wdata for 2 cycles; one dm_ack; dm_rdata unchanged.
3. Simultaneous single requests. IF read of 0x20 and DM load of 0x200 issued together after reset. Required: IF is served first, then DM; dm_rdata equals the RAM word at 0x200; no overlap of strobes between the two accesses.
4. Fairness. Both req held high for 4 transactions. Required: grant order IF, DM, IF, DM; each ack exactly 1 cycle; busy deasserts for exactly 1 IDLE cycle between accesses.
5. Reset mid-access. Assert reset during the first ACCESS cycle of a DM store. Required: ram_cs/ram_we/ram_wdata_oe go to 0 before the next clock edge; no dm_ack. After release, a new if_req to 0x40 completes normally.
6. Operand stability. Change dm_addr from 0x300 to 0x308 during ACCESS. Required: ram_addr stays 0x300 for the whole access.
